// File: rtl/ads1256_spi_responder.sv
// ADS1256 data-path emulator: periodic DRDY, command decode, RDATA readout (SPI mode 1).
// Optional overrun flag output enabled by defining ADS_RESPONDER_OVERRUN_EN.
module ads1256_spi_responder #(
    parameter int unsigned SAMPLE_PERIOD = 3000,
    parameter int unsigned DATA_W        = 24,
    parameter logic [7:0]  CMD_RDATA     = 8'h01
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              enable_i,
    input  logic [DATA_W-1:0] sample_i,
    input  logic              SCLK_i,
    input  logic              DIN_i,
    input  logic              CS_L_i,
    output logic              DOUT_o,
    output logic              DRDY_o,
    output logic [7:0]        cmd_o,
    output logic              cmd_valid_o,
    output logic              busy_o
`ifdef ADS_RESPONDER_OVERRUN_EN
    ,
    output logic              overrun_o
`endif
);

    localparam int unsigned CNT_W  = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int unsigned DCNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    logic [2:0] sclk_s;
    logic [1:0] din_s;
    logic [1:0] cs_s;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [7:0]          cmd_sr_q, cmd_sr_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [DCNT_W-1:0]   data_cnt_q, data_cnt_d;
    logic                dout_q, dout_d;
    logic                drdy_q, drdy_d;
    logic [7:0]          cmd_q, cmd_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic                busy_q, busy_d;
`ifdef ADS_RESPONDER_OVERRUN_EN
    logic                ovr_q, ovr_d;
`endif

    logic       sclk_rise, sclk_fall, din_sync, cs_high, tc;
    logic [7:0] cmd_byte;

    assign sclk_rise = sclk_s[1] & ~sclk_s[2];
    assign sclk_fall = ~sclk_s[1] & sclk_s[2];
    assign din_sync  = din_s[1];
    assign cs_high   = cs_s[1];

    // Pin synchronisers; sclk_s[2] is the edge-detect reference copy
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            sclk_s <= 3'b000;
            din_s  <= 2'b00;
            cs_s   <= 2'b11;
        end else begin
            sclk_s <= {sclk_s[1:0], SCLK_i};
            din_s  <= {din_s[0], DIN_i};
            cs_s   <= {cs_s[0], CS_L_i};
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hold_q      <= '0;
            shreg_q     <= '0;
            cmd_sr_q    <= '0;
            bit_cnt_q   <= '0;
            data_cnt_q  <= '0;
            dout_q      <= 1'b0;
            drdy_q      <= 1'b1;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef ADS_RESPONDER_OVERRUN_EN
            ovr_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            shreg_q     <= shreg_d;
            cmd_sr_q    <= cmd_sr_d;
            bit_cnt_q   <= bit_cnt_d;
            data_cnt_q  <= data_cnt_d;
            dout_q      <= dout_d;
            drdy_q      <= drdy_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            busy_q      <= busy_d;
`ifdef ADS_RESPONDER_OVERRUN_EN
            ovr_q       <= ovr_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        shreg_d     = shreg_q;
        cmd_sr_d    = cmd_sr_q;
        bit_cnt_d   = bit_cnt_q;
        data_cnt_d  = data_cnt_q;
        dout_d      = dout_q;
        drdy_d      = drdy_q;
        cmd_d       = cmd_q;
        cmd_valid_d = 1'b0;
        tc          = 1'b0;
        cmd_byte    = {cmd_sr_q[6:0], din_sync};
`ifdef ADS_RESPONDER_OVERRUN_EN
        ovr_d       = ovr_q;
`endif

        if (!enable_i) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(SAMPLE_PERIOD - 1)) begin
            cnt_d = '0;
            tc    = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (cs_high) begin
            state_d    = IDLE;
            bit_cnt_d  = '0;
            data_cnt_d = '0;
            dout_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    dout_d  = 1'b0;
                    state_d = CMD;
                end
                CMD: begin
                    if (sclk_fall) begin
                        cmd_sr_d  = cmd_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            cmd_d       = cmd_byte;
                            cmd_valid_d = 1'b1;
                            bit_cnt_d   = '0;
                            if (cmd_byte == CMD_RDATA) begin
                                shreg_d    = hold_q;
                                data_cnt_d = '0;
                                state_d    = DATA;
                            end
                        end
                    end
                end
                DATA: begin
                    // Shift out on rise; the fall after the last bit closes the readout
                    if (sclk_rise && data_cnt_q != DCNT_W'(DATA_W)) begin
                        dout_d     = shreg_q[DATA_W-1];
                        shreg_d    = {shreg_q[DATA_W-2:0], 1'b0};
                        data_cnt_d = data_cnt_q + DCNT_W'(1);
                        if (data_cnt_q == '0) drdy_d = 1'b1;
                    end else if (sclk_fall && data_cnt_q == DCNT_W'(DATA_W)) begin
                        state_d    = CMD;
                        dout_d     = 1'b0;
                        data_cnt_d = '0;
`ifdef ADS_RESPONDER_OVERRUN_EN
                        ovr_d      = 1'b0;
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A new sample takes priority over a same-cycle DRDY release
        if (tc) begin
            hold_d = sample_i;
            drdy_d = 1'b0;
`ifdef ADS_RESPONDER_OVERRUN_EN
            if (!drdy_q) ovr_d = 1'b1;
`endif
        end

        busy_d = (state_d == DATA);
    end

    assign DOUT_o      = dout_q;
    assign DRDY_o      = drdy_q;
    assign cmd_o       = cmd_q;
    assign cmd_valid_o = cmd_valid_q;
    assign busy_o      = busy_q;
`ifdef ADS_RESPONDER_OVERRUN_EN
    assign overrun_o   = ovr_q;
`endif

endmodule
